lane_to_slice_streamer: RTL and testbench

- Sequential transposer for the Keccak datapath.
- Accepts the 1600-bit state serially as 25 lanes of 64 bits, one per handshake, into an internal buffer.
- Emits the same state as 64 slices of 25 bits, one per handshake, for slice-oriented round logic (rotate/theta).
- Serial counterpart to the combinational lane/matrix converters. Same bit mapping: slice i bit (24-j) = lane j bit (63-i).

---
 rtl/lane_to_slice_streamer.sv | 141 ++++++++++++++
 tb/tb_lane_to_slice_streamer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_to_slice_streamer.sv
// Keccak lane-to-slice streamer: 25 x 64-bit lanes in, 64 x 25-bit slices out.
// Optional out_parity port (XOR of out_slice) under `define SLICE_PARITY_EN.
module lane_to_slice_streamer #(
    parameter int LANES  = 25,
    parameter int W      = 64,
    parameter int IDX_W  = 6,
    parameter int LIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES-1:0]  out_slice,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy
`ifdef SLICE_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic {
        LOAD,
        DRAIN
    } state_t;

    localparam logic [LIDX_W-1:0] LAST_LANE  = LIDX_W'(LANES - 1);
    localparam logic [IDX_W-1:0]  LAST_SLICE = IDX_W'(W - 1);

    state_t              state;
    logic [LIDX_W-1:0]   lane_cnt;
    logic [IDX_W-1:0]    slice_cnt;
    logic [W-1:0]        lanes_q [LANES];
    logic [LANES-1:0]    slice_q;
    logic                busy_q;
`ifdef SLICE_PARITY_EN
    logic                parity_q;
`endif

    logic                accept;
    logic                xfer;
    logic                last_lane;
    logic                last_slice;
    logic [W-1:0]        view [LANES];
    logic [IDX_W-1:0]    nidx;
    logic [IDX_W-1:0]    bit_sel;
    logic [LANES-1:0]    nslice;

    assign accept     = (state == LOAD) && in_valid;
    assign xfer       = (state == DRAIN) && out_ready;
    assign last_lane  = (lane_cnt == LAST_LANE);
    assign last_slice = (slice_cnt == LAST_SLICE);

    // Next slice to present: the buffer as it will be after this cycle's
    // write (so slice 0 can include lane 24 on the final accept), read at
    // the slice index that becomes current next cycle.
    always_comb begin
        view = lanes_q;
        if (accept) begin
            view[lane_cnt] = in_lane;
        end
        nidx    = accept ? '0 : slice_cnt + 1'b1;
        bit_sel = LAST_SLICE - nidx;
        nslice  = '0;
        for (int j = 0; j < LANES; j++) begin
            nslice[LANES-1-j] = view[j][bit_sel];
        end
    end

    // Control FSM, lane buffer and registered slice output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            lane_cnt  <= '0;
            slice_cnt <= '0;
            slice_q   <= '0;
            busy_q    <= 1'b0;
`ifdef SLICE_PARITY_EN
            parity_q  <= 1'b0;
`endif
            for (int j = 0; j < LANES; j++) begin
                lanes_q[j] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        lanes_q[lane_cnt] <= in_lane;
                        busy_q            <= 1'b1;
                        if (last_lane) begin
                            state     <= DRAIN;
                            lane_cnt  <= '0;
                            slice_cnt <= '0;
                            slice_q   <= nslice;
`ifdef SLICE_PARITY_EN
                            parity_q  <= ^nslice;
`endif
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (last_slice) begin
                            state     <= LOAD;
                            slice_cnt <= '0;
                            busy_q    <= 1'b0;
                            slice_q   <= '0;
`ifdef SLICE_PARITY_EN
                            parity_q  <= 1'b0;
`endif
                        end else begin
                            slice_cnt <= slice_cnt + 1'b1;
                            slice_q   <= nslice;
`ifdef SLICE_PARITY_EN
                            parity_q  <= ^nslice;
`endif
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_index = slice_cnt;
    assign out_last  = (state == DRAIN) && last_slice;
    assign out_slice = slice_q;
    assign busy      = busy_q;
`ifdef SLICE_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_lane_to_slice_streamer.sv
// Randomized self-checking bench for lane_to_slice_streamer.
// Behavioural model of the transpose; per-cycle compare plus literal checks.
module tb_lane_to_slice_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_lane = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [24:0] out_slice;
    logic [5:0]  out_index;
    logic        out_last;
    logic        busy;
`ifdef SLICE_PARITY_EN
    logic        out_parity;
`endif

    lane_to_slice_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lane   (in_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slice (out_slice),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SLICE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, counts and captured lanes.
    bit          m_load = 1'b1;
    int          m_cnt = 0;
    int          m_idx = 0;
    bit          m_busy = 1'b0;
    logic [63:0] m_lanes [25];
    bit          chk_en = 1'b0;
    logic [24:0] got [$];

    function automatic logic [24:0] slice_from(input logic [63:0] lv [25],
                                               input int i);
        logic [24:0] s;
        for (int j = 0; j < 25; j++) s[24-j] = lv[j][63-i];
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_slice);
        if (rst) begin
            chk_en = 1'b1;
            m_load = 1'b1;
            m_cnt  = 0;
            m_idx  = 0;
            m_busy = 1'b0;
        end else if (m_load) begin
            if (in_valid) begin
                m_lanes[m_cnt] = in_lane;
                m_cnt++;
                m_busy = 1'b1;
                if (m_cnt == 25) begin
                    m_load = 1'b0;
                    m_cnt  = 0;
                    m_idx  = 0;
                end
            end
        end else if (out_ready) begin
            if (m_idx == 63) begin
                m_load = 1'b1;
                m_idx  = 0;
                m_busy = 1'b0;
            end else begin
                m_idx++;
            end
        end
    end

    bit          prev_stall = 1'b0;
    logic [24:0] prev_slice;
    logic [5:0]  prev_index;

    always @(negedge clk) begin
        logic [24:0] e;
        if (chk_en) begin
            e = slice_from(m_lanes, m_idx);
            check("in_ready", {63'd0, in_ready}, {63'd0, m_load});
            check("out_valid", {63'd0, out_valid}, {63'd0, !m_load});
            check("busy", {63'd0, busy}, {63'd0, m_busy});
            check("out_index", {58'd0, out_index}, 64'(m_idx));
            check("out_last", {63'd0, out_last}, {63'd0, (!m_load && m_idx == 63)});
            if (!m_load) begin
                check("out_slice", {39'd0, out_slice}, {39'd0, e});
`ifdef SLICE_PARITY_EN
                check("out_parity", {63'd0, out_parity}, {63'd0, ^e});
`endif
            end
            if (prev_stall) begin
                check("stall_slice", {39'd0, out_slice}, {39'd0, prev_slice});
                check("stall_index", {58'd0, out_index}, {58'd0, prev_index});
            end
            prev_stall = out_valid && !out_ready && !rst;
            prev_slice = out_slice;
            prev_index = out_index;
        end
    end

    // Consumer: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
    int rdy_mode = 0;
    int rdy_phase = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rdy_phase % 3 == 0);
                rdy_phase++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Called at posedge+1; returns at posedge+1 after the last accept.
    task automatic load_lanes(input logic [63:0] lv [25], input int n,
                              input int gap_at, input bit rnd_gaps);
        int t;
        for (int j = 0; j < n; j++) begin
            if (j == gap_at || (rnd_gaps && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_lane  = lv[j];
            t = 0;
            do begin
                @(posedge clk);
                t++;
            end while (!in_ready && t < 2000);
            #1;
            if (t >= 2000) check("accept_timeout", 64'(t), 64'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit hold);
        int t = 0;
        if (hold) in_valid = 1'b1;
        while (got.size() < 64 && t < 3000) begin
            @(posedge clk);
            #1;
            in_lane = {$urandom, $urandom};
            t++;
        end
        in_valid = 1'b0;
        check("drain_count", 64'(got.size()), 64'd64);
    endtask

    task automatic check_got(input string name, input logic [63:0] lv [25]);
        for (int i = 0; i < 64 && i < got.size(); i++)
            check(name, {39'd0, got[i]}, {39'd0, slice_from(lv, i)});
    endtask

    logic [63:0] lv [25];

    initial begin
        foreach (m_lanes[j]) m_lanes[j] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_index", {58'd0, out_index}, 64'd0);

        // Diagonal pattern
        for (int j = 0; j < 25; j++) lv[j] = 64'h1 << (63 - j);
        got.delete();
        load_lanes(lv, 25, -1, 1'b0);
        check("first_valid_latency", {63'd0, out_valid}, 64'd1);
        wait_drain(1'b0);
        check("ready_after_drain", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 64 && i < got.size(); i++)
            check("diag_slice", {39'd0, got[i]},
                  (i < 25) ? (64'h1 << (24 - i)) : 64'd0);

        // All ones
        for (int j = 0; j < 25; j++) lv[j] = '1;
        got.delete();
        load_lanes(lv, 25, -1, 1'b0);
        wait_drain(1'b0);
        for (int i = 0; i < 64 && i < got.size(); i++)
            check("ones_slice", {39'd0, got[i]}, 64'h1FF_FFFF);

        // Backpressure with diagonal load
        for (int j = 0; j < 25; j++) lv[j] = 64'h1 << (63 - j);
        rdy_mode = 1;
        got.delete();
        load_lanes(lv, 25, -1, 1'b0);
        wait_drain(1'b0);
        for (int i = 0; i < 64 && i < got.size(); i++)
            check("bp_slice", {39'd0, got[i]},
                  (i < 25) ? (64'h1 << (24 - i)) : 64'd0);

        // Input gap between lanes 5 and 6, in_valid held through drain
        rdy_mode = 2;
        for (int j = 0; j < 25; j++) lv[j] = {$urandom, $urandom};
        got.delete();
        load_lanes(lv, 25, 6, 1'b0);
        wait_drain(1'b1);
        check_got("gap_slice", lv);

        // Reset mid-load
        rdy_mode = 0;
        for (int j = 0; j < 25; j++) lv[j] = {$urandom, $urandom};
        load_lanes(lv, 12, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_load_busy", {63'd0, busy}, 64'd0);
        for (int j = 0; j < 25; j++) lv[j] = '0;
        lv[0] = 64'h8000_0000_0000_0000;
        got.delete();
        load_lanes(lv, 25, -1, 1'b0);
        wait_drain(1'b0);
        for (int i = 0; i < 64 && i < got.size(); i++)
            check("rst_slice", {39'd0, got[i]}, (i == 0) ? 64'h100_0000 : 64'd0);

        // Reset mid-drain
        rdy_mode = 2;
        for (int j = 0; j < 25; j++) lv[j] = {$urandom, $urandom};
        load_lanes(lv, 25, -1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_drain_valid", {63'd0, out_valid}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_drain_idle", {63'd0, out_valid}, 64'd0);

        // Random blocks
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 25; j++) lv[j] = {$urandom, $urandom};
            got.delete();
            load_lanes(lv, 25, -1, 1'b1);
            wait_drain(b[0]);
            check_got("rand_slice", lv);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
